// File: rtl/vx_mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: port index width helper and
// the request layout for the default socket configuration.
package VX_gpu_pkg;

  function automatic int port_bits(input int nports);
    return (nports > 1) ? $clog2(nports) : 1;
  endfunction

  localparam int VX_MEM_NPORTS     = 2;
  localparam int VX_MEM_ADDR_WIDTH = 26;
  localparam int VX_MEM_DATA_WIDTH = 512;
  localparam int VX_MEM_TAG_WIDTH  = 8;
  localparam int VX_MEM_PORT_BITS  = port_bits(VX_MEM_NPORTS);

  typedef struct packed {
    logic                                        rw;
    logic [VX_MEM_ADDR_WIDTH-1:0]                addr;
    logic [VX_MEM_DATA_WIDTH-1:0]                data;
    logic [VX_MEM_DATA_WIDTH/8-1:0]              byteen;
    logic [VX_MEM_TAG_WIDTH+VX_MEM_PORT_BITS-1:0] tag;
  } vx_mem_arb_req_t;

endpackage

// File: rtl/vx_mem_port_arbiter_rr_arbiter.sv
// Round-robin grant over NPORTS requesters; the pointer advances past the
// granted port only when the grant is consumed (enable high).
module vx_rr_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NPORTS = 2,
  localparam int IDX_BITS = port_bits(NPORTS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NPORTS-1:0]   requests,
  input  logic                enable,
  output logic [NPORTS-1:0]   grant_onehot,
  output logic [IDX_BITS-1:0] grant_index,
  output logic                grant_valid
);

  logic [IDX_BITS-1:0] ptr_reg, ptr_next;
  int scan_pos;

  // Scan from the pointer upward, wrapping; the first hit wins.
  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    scan_pos     = 0;
    for (int k = 0; k < NPORTS; k++) begin
      scan_pos = (int'(ptr_reg) + k) % NPORTS;
      if (!grant_valid && requests[scan_pos]) begin
        grant_valid            = 1'b1;
        grant_index            = IDX_BITS'(scan_pos);
        grant_onehot[scan_pos] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (enable && grant_valid) begin
      ptr_next = IDX_BITS'((int'(grant_index) + 1) % NPORTS);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/vx_mem_port_arbiter.sv
// Folds NPORTS memory request ports onto one downstream port and routes responses
// back by the port index in the tag LSBs. VX_MEM_ARB_PERF_EN adds perf counters.
module vx_mem_port_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 512,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16,
  localparam int PORT_BITS     = port_bits(NPORTS),
  localparam int OUT_TAG_WIDTH = TAG_WIDTH + PORT_BITS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NPORTS-1:0]              in_req_valid,
  input  logic [NPORTS-1:0]              in_req_rw,
  input  logic [NPORTS*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [NPORTS*DATA_WIDTH-1:0]   in_req_data,
  input  logic [NPORTS*DATA_WIDTH/8-1:0] in_req_byteen,
  input  logic [NPORTS*TAG_WIDTH-1:0]    in_req_tag,
  output logic [NPORTS-1:0]              in_req_ready,
  output logic [NPORTS-1:0]              in_rsp_valid,
  output logic [NPORTS*DATA_WIDTH-1:0]   in_rsp_data,
  output logic [NPORTS*TAG_WIDTH-1:0]    in_rsp_tag,
  input  logic [NPORTS-1:0]              in_rsp_ready,
  output logic                           out_req_valid,
  output logic                           out_req_rw,
  output logic [ADDR_WIDTH-1:0]          out_req_addr,
  output logic [DATA_WIDTH-1:0]          out_req_data,
  output logic [DATA_WIDTH/8-1:0]        out_req_byteen,
  output logic [OUT_TAG_WIDTH-1:0]       out_req_tag,
  input  logic                           out_req_ready,
  input  logic                           out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          out_rsp_data,
  input  logic [OUT_TAG_WIDTH-1:0]       out_rsp_tag,
  output logic                           out_rsp_ready,
  output logic                           busy,
  output logic                           err
`ifdef VX_MEM_ARB_PERF_EN
  ,
  output logic [NPORTS*32-1:0]           perf_reqs,
  output logic [31:0]                    perf_stalls
`endif
);

  localparam int CNT_BITS = $clog2(MAX_PENDING + 1);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic                     rw;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [BE_WIDTH-1:0]      byteen;
    logic [OUT_TAG_WIDTH-1:0] tag;
  } req_t;

  logic                 accept;
  logic [NPORTS-1:0]    eligible, grant, room, pend_nz, zero_err;
  logic [PORT_BITS-1:0] grant_idx;
  logic                 grant_valid;
  req_t                 req_sel, req_reg;
  logic                 req_valid_reg, err_reg;
  logic [PORT_BITS-1:0] rsp_idx;
  logic                 rsp_idx_ok, rsp_fire;

  // Output register takes a new request whenever it is empty or draining this cycle.
  assign accept = !req_valid_reg || out_req_ready;

  vx_rr_arbiter #(.NPORTS(NPORTS)) u_rr (
    .clk          (clk),
    .reset_n      (reset_n),
    .requests     (eligible),
    .enable       (accept),
    .grant_onehot (grant),
    .grant_index  (grant_idx),
    .grant_valid  (grant_valid)
  );

  assign in_req_ready = grant & {NPORTS{accept}};

  always_comb begin
    req_sel        = '0;
    req_sel.rw     = in_req_rw[grant_idx];
    req_sel.addr   = in_req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    req_sel.data   = in_req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    req_sel.byteen = in_req_byteen[int'(grant_idx)*BE_WIDTH +: BE_WIDTH];
    req_sel.tag    = {in_req_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH], grant_idx};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_valid_reg <= 1'b0;
      req_reg       <= '0;
    end else if (accept) begin
      req_valid_reg <= grant_valid;
      if (grant_valid) begin
        req_reg <= req_sel;
      end
    end
  end

  assign out_req_valid  = req_valid_reg;
  assign out_req_rw     = req_reg.rw;
  assign out_req_addr   = req_reg.addr;
  assign out_req_data   = req_reg.data;
  assign out_req_byteen = req_reg.byteen;
  assign out_req_tag    = req_reg.tag;

  // Responses carrying an index with no matching port are swallowed and flagged.
  assign rsp_idx       = out_rsp_tag[PORT_BITS-1:0];
  assign rsp_idx_ok    = int'(rsp_idx) < NPORTS;
  assign out_rsp_ready = rsp_idx_ok ? in_rsp_ready[rsp_idx] : 1'b1;
  assign rsp_fire      = out_rsp_valid && out_rsp_ready;

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      logic [CNT_BITS-1:0] pend_reg;
      logic                inc, dec;

      assign in_rsp_valid[gi]                         = out_rsp_valid && rsp_idx_ok && (int'(rsp_idx) == gi);
      assign in_rsp_data[gi*DATA_WIDTH +: DATA_WIDTH] = out_rsp_data;
      assign in_rsp_tag[gi*TAG_WIDTH +: TAG_WIDTH]    = out_rsp_tag[OUT_TAG_WIDTH-1:PORT_BITS];

      assign inc          = in_req_ready[gi] && !in_req_rw[gi];
      assign dec          = rsp_fire && in_rsp_valid[gi];
      assign zero_err[gi] = dec && (pend_reg == '0);
      assign pend_nz[gi]  = (pend_reg != '0);
      assign room[gi]     = pend_reg < CNT_BITS'(MAX_PENDING);
      assign eligible[gi] = in_req_valid[gi] && (in_req_rw[gi] || room[gi]);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pend_reg <= '0;
        end else if (inc && !dec) begin
          pend_reg <= pend_reg + CNT_BITS'(1);
        end else if (dec && !inc && (pend_reg != '0)) begin
          pend_reg <= pend_reg - CNT_BITS'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 1'b0;
    end else if ((|zero_err) || (out_rsp_valid && !rsp_idx_ok)) begin
      err_reg <= 1'b1;
    end
  end

  assign err  = err_reg;
  assign busy = req_valid_reg || (|pend_nz);

`ifdef VX_MEM_ARB_PERF_EN
  logic [31:0] stalls_reg;

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_perf
      logic [31:0] reqs_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          reqs_reg <= '0;
        end else if (in_req_ready[gi]) begin
          reqs_reg <= reqs_reg + 32'd1;
        end
      end
      assign perf_reqs[gi*32 +: 32] = reqs_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stalls_reg <= '0;
    end else if (req_valid_reg && !out_req_ready) begin
      stalls_reg <= stalls_reg + 32'd1;
    end
  end
  assign perf_stalls = stalls_reg;
`endif

endmodule

// File: tb/tb_vx_mem_port_arbiter.sv
// Self-checking bench for vx_mem_port_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural model of the arbiter.
module tb_vx_mem_port_arbiter;

  localparam int N   = 2;
  localparam int AW  = 26;
  localparam int DW  = 512;
  localparam int TW  = 8;
  localparam int MP  = 16;
  localparam int OTW = 9;
  localparam int BEW = DW / 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     in_req_valid, in_req_rw, in_req_ready;
  logic [N*AW-1:0]  in_req_addr;
  logic [N*DW-1:0]  in_req_data;
  logic [N*BEW-1:0] in_req_byteen;
  logic [N*TW-1:0]  in_req_tag;
  logic [N-1:0]     in_rsp_valid, in_rsp_ready;
  logic [N*DW-1:0]  in_rsp_data;
  logic [N*TW-1:0]  in_rsp_tag;
  logic             out_req_valid, out_req_rw, out_req_ready;
  logic [AW-1:0]    out_req_addr;
  logic [DW-1:0]    out_req_data;
  logic [BEW-1:0]   out_req_byteen;
  logic [OTW-1:0]   out_req_tag;
  logic             out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]    out_rsp_data;
  logic [OTW-1:0]   out_rsp_tag;
  logic             busy, err;

  always #5 clk = ~clk;

  vx_mem_port_arbiter #(
    .NPORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_data(in_req_data), .in_req_byteen(in_req_byteen), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
    .out_req_data(out_req_data), .out_req_byteen(out_req_byteen), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
    .out_rsp_ready(out_rsp_ready),
    .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: contents of the downstream register, per-port outstanding reads, rr pointer, sticky error.
  bit             m_valid;
  bit             m_rw;
  logic [AW-1:0]  m_addr;
  logic [63:0]    m_data_lo;
  logic [BEW-1:0] m_be;
  logic [OTW-1:0] m_tag;
  int             m_pend [N];
  int             m_ptr;
  bit             m_err;

  logic [N-1:0]   obs_ready, obs_rsp_valid;
  logic           obs_rsp_ready, obs_err, obs_busy;
  logic [OTW-1:0] obs_out_tag;
  logic [TW-1:0]  obs_rsp_tag0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pend  = '{0, 0};
    m_ptr   = 0;
    m_err   = 1'b0;
  endtask

  task automatic set_port(input int p, input bit v, input bit rw, input logic [TW-1:0] tag);
    in_req_valid[p]            = v;
    in_req_rw[p]               = rw;
    in_req_tag[p*TW +: TW]     = tag;
    in_req_addr[p*AW +: AW]    = AW'($urandom);
    for (int w = 0; w < DW/32; w++) in_req_data[p*DW + w*32 +: 32] = $urandom;
    in_req_byteen[p*BEW +: BEW] = {$urandom, $urandom};
  endtask

  task automatic set_rsp(input bit v, input int p, input logic [TW-1:0] tag);
    logic [0:0] pb;
    pb            = p[0:0];
    out_rsp_valid = v;
    out_rsp_tag   = {tag, pb};
    for (int w = 0; w < DW/32; w++) out_rsp_data[w*32 +: 32] = $urandom;
  endtask

  // One clock: compare all outputs at the falling edge, then advance the model.
  task automatic step();
    int g, p, idx;
    bit accept, fire, inc, dec;
    logic [N-1:0] exp_ready, exp_rval;
    logic exp_rrdy;
    @(negedge clk);
    accept = !m_valid || out_req_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      p = (m_ptr + k) % N;
      if (g < 0 && in_req_valid[p] && (in_req_rw[p] || m_pend[p] < MP)) g = p;
    end
    exp_ready = (accept && g >= 0) ? N'(1 << g) : '0;
    idx       = int'(out_rsp_tag[0]);
    exp_rrdy  = in_rsp_ready[idx];
    exp_rval  = out_rsp_valid ? N'(1 << idx) : '0;

    obs_ready     = in_req_ready;
    obs_rsp_valid = in_rsp_valid;
    obs_rsp_ready = out_rsp_ready;
    obs_err       = err;
    obs_busy      = busy;
    obs_out_tag   = out_req_tag;
    obs_rsp_tag0  = in_rsp_tag[TW-1:0];

    check_eq("in_req_ready", in_req_ready, exp_ready);
    check_eq("in_rsp_valid", in_rsp_valid, exp_rval);
    check_eq("out_rsp_ready", out_rsp_ready, exp_rrdy);
    if (out_rsp_valid) begin
      check_eq("in_rsp_tag", in_rsp_tag[idx*TW +: TW], out_rsp_tag[OTW-1:1]);
      check_eq("in_rsp_data", in_rsp_data[idx*DW +: 64], out_rsp_data[63:0]);
    end
    check_eq("out_req_valid", out_req_valid, m_valid);
    if (m_valid) begin
      check_eq("out_req_tag", out_req_tag, m_tag);
      check_eq("out_req_addr", out_req_addr, m_addr);
      check_eq("out_req_rw", out_req_rw, m_rw);
      check_eq("out_req_data", out_req_data[63:0], m_data_lo);
      check_eq("out_req_byteen", out_req_byteen, m_be);
    end
    check_eq("busy", busy, m_valid || m_pend[0] > 0 || m_pend[1] > 0);
    check_eq("err", err, m_err);

    fire = out_rsp_valid && exp_rrdy;
    for (int q = 0; q < N; q++) begin
      inc = accept && (g == q) && !in_req_rw[q];
      dec = fire && (idx == q);
      if (dec && m_pend[q] == 0) m_err = 1'b1;
      if (inc && !dec) m_pend[q]++;
      else if (dec && !inc && m_pend[q] > 0) m_pend[q]--;
    end
    if (accept) begin
      if (g >= 0) begin
        m_valid   = 1'b1;
        m_rw      = in_req_rw[g];
        m_addr    = in_req_addr[g*AW +: AW];
        m_data_lo = in_req_data[g*DW +: 64];
        m_be      = in_req_byteen[g*BEW +: BEW];
        m_tag     = {in_req_tag[g*TW +: TW], g[0:0]};
        m_ptr     = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Empty the request register and answer every outstanding read.
  task automatic drain();
    int p;
    set_port(0, 0, 0, 8'h00);
    set_port(1, 0, 0, 8'h00);
    out_req_ready = 1'b1;
    in_rsp_ready  = '1;
    for (int k = 0; k < 80 && (m_valid || m_pend[0] > 0 || m_pend[1] > 0); k++) begin
      p = (m_pend[0] > 0) ? 0 : 1;
      set_rsp(m_pend[p] > 0, p, 8'($urandom));
      step();
    end
    set_rsp(0, 0, 8'h00);
    step();
    check_eq("drain_busy", obs_busy, 1'b0);
  endtask

  initial begin
    int acc;
    logic [OTW-1:0] first_tag;
    reset_n       = 1'b0;
    in_req_valid  = '0;
    in_req_rw     = '0;
    in_req_addr   = '0;
    in_req_data   = '0;
    in_req_byteen = '0;
    in_req_tag    = '0;
    in_rsp_ready  = '1;
    out_req_ready = 1'b1;
    out_rsp_valid = 1'b0;
    out_rsp_data  = '0;
    out_rsp_tag   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_req_valid", out_req_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err, 1'b0);
    reset_n = 1'b1;

    // Both ports streaming reads: grants alternate, one per cycle.
    for (int i = 0; i < 8; i++) begin
      set_port(0, 1, 0, 8'(i));
      set_port(1, 1, 0, 8'(i + 8'h80));
      step();
      check_eq("alt_grant", obs_ready, (i % 2) ? 2'b10 : 2'b01);
    end
    drain();

    // Tag append and strip.
    set_port(0, 1, 0, 8'h5A);
    step();
    check_eq("tag_accept", obs_ready, 2'b01);
    set_port(0, 0, 0, 8'h00);
    step();
    check_eq("tag_out", obs_out_tag, 9'h0B4);
    set_rsp(1, 0, 8'h5A);
    step();
    check_eq("tag_rsp_valid", obs_rsp_valid, 2'b01);
    check_eq("tag_rsp_strip", obs_rsp_tag0, 8'h5A);
    drain();

    // Pending limit on port 1: 16 reads go, the 17th waits, writes still go.
    acc = 0;
    for (int i = 0; i < MP + 1; i++) begin
      set_port(1, 1, 0, 8'(i));
      step();
      acc += int'(obs_ready[1]);
    end
    check_eq("limit_count", acc, MP);
    check_eq("limit_held", obs_ready[1], 1'b0);
    set_port(1, 1, 1, 8'hEE);
    step();
    check_eq("limit_write", obs_ready[1], 1'b1);
    drain();

    // Downstream stall with a full register.
    out_req_ready = 1'b0;
    set_port(0, 1, 0, 8'h33);
    step();
    first_tag = 9'h066;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_ready", obs_ready, 2'b00);
      check_eq("stall_tag", obs_out_tag, first_tag);
    end
    drain();

    // Response back-pressure, then accept and response for port 1 together.
    set_port(1, 1, 0, 8'h11);
    step();
    set_port(1, 0, 0, 8'h00);
    step();
    set_rsp(1, 1, 8'h11);
    in_rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_rsp_ready", obs_rsp_ready, 1'b0);
      check_eq("bp_rsp_valid", obs_rsp_valid, 2'b10);
    end
    in_rsp_ready = 2'b11;
    set_port(1, 1, 0, 8'h22);
    step();
    check_eq("bp_release", obs_rsp_ready, 1'b1);
    check_eq("same_cycle_accept", obs_ready, 2'b10);
    set_rsp(0, 0, 8'h00);
    drain();

    // Response to an idle port sets a sticky error; reset clears everything at once.
    set_rsp(1, 1, 8'h77);
    step();
    set_rsp(0, 0, 8'h00);
    step();
    check_eq("err_set", obs_err, 1'b1);
    repeat (3) step();
    check_eq("err_sticky", obs_err, 1'b1);
    out_req_ready = 1'b0;
    set_port(0, 1, 1, 8'h44);
    step();
    step();
    reset_n = 1'b0;
    #1;
    check_eq("arst_out_req_valid", out_req_valid, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_err", err, 1'b0);
    model_reset();
    set_port(0, 0, 0, 8'h00);
    out_req_ready = 1'b1;
    #2;
    reset_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int p;
      for (int q = 0; q < N; q++) set_port(q, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom));
      out_req_ready = $urandom_range(0, 3) != 0;
      in_rsp_ready  = 2'($urandom);
      if (m_pend[0] > 0 && m_pend[1] > 0) p = $urandom_range(0, 1);
      else p = (m_pend[0] > 0) ? 0 : 1;
      set_rsp((m_pend[p] > 0) && ($urandom_range(0, 1) == 1), p, 8'($urandom));
      step();
    end
    set_rsp(0, 0, 8'h00);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
